// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
//
// Purpose: request/response bundle between the ALU pipeline and the
// iterative multiply/divide engine (mult_div_unit).
//
// Signals:
//   validIn    request strobe, taken only while readyOut is high
//   op         00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   SrcA       multiplicand / dividend
//   SrcB       multiplier / divisor
//   readyOut   engine is idle and can take a request
//   validOut   one-cycle completion pulse
//   Hi         product high half / remainder (held)
//   Lo         product low half / quotient (held)
//   divByZero  last divide had a zero divisor (held with Hi/Lo)
//
// Modports:
//   master  the requester (pipeline or testbench)
//   slave   the engine
// ---------------------------------------------------------------------------
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);

  logic             validIn;
  logic [1:0]       op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             readyOut;
  logic             validOut;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             divByZero;

  modport master (
    output validIn, op, SrcA, SrcB,
    input  readyOut, validOut, Hi, Lo, divByZero
  );

  modport slave (
    input  validIn, op, SrcA, SrcB,
    output readyOut, validOut, Hi, Lo, divByZero
  );

endinterface

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Purpose: iterative multiply/divide engine for the HI/LO path. Executes
// MULTU, MULT, DIVU and DIV on WIDTH-bit operands. Multiply retires
// RADIX_BITS multiplier bits per cycle; divide is restoring, one quotient
// bit per cycle. Signed operations run on magnitudes and a final FIX cycle
// applies the signs and loads the held Hi/Lo result registers.
//
// Parameters:
//   WIDTH       operand width; Hi and Lo are WIDTH bits each
//   RADIX_BITS  multiplier bits per multiply iteration (1, 2, 4 or 8;
//               WIDTH must be a multiple of it)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mult_div_unit_if slave modport (validIn, op, SrcA, SrcB in;
//          readyOut, validOut, Hi, Lo, divByZero out); the interface must
//          be instantiated with the same WIDTH as this module
//
// Optional build macro:
//   MULT_EARLY_TERM_EN  when defined, a multiply finishes as soon as the
//                       remaining multiplier bits are all zero (and skips
//                       iteration entirely when |SrcA| is zero). Results are
//                       identical; only multiply latency changes.
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_div_unit_if.slave bus
);

  localparam int MUL_ITERS = WIDTH / RADIX_BITS;
  localparam int DIV_ITERS = WIDTH;
  localparam int CW        = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Working registers. During a multiply {r_accHi, r_accLo} is the 2*WIDTH
  // product accumulator. During a divide r_accHi is the partial remainder
  // and r_accLo starts as the dividend and fills up with quotient bits.
  logic [WIDTH-1:0]   r_accHi;
  logic [WIDTH-1:0]   r_accLo;
  // The |SrcA| magnitude is the operand consumed RADIX_BITS at a time, so the
  // early-termination latency follows the bit length of |SrcA|. The product
  // is the same either way round.
  logic [WIDTH-1:0]   r_mplier;
  // Shifted addend for multiply; its low half doubles as the divisor.
  logic [2*WIDTH-1:0] r_mcand;
  logic [CW-1:0]      r_count;
  logic               r_signA;
  logic               r_signB;
  logic               r_isMul;
  logic               r_dbzPending;

  // Held results.
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dbz;
  logic               r_validOut;

  logic               w_ready;
  logic               w_accept;
  logic               w_signA;
  logic               w_signB;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic               w_isDbz;
  logic               w_mulSkip;
  logic               w_mulLast;
  logic               w_divLast;
  logic               w_mulDone;
  logic [WIDTH-1:0]   w_mplierNext;
  logic [2*WIDTH-1:0] w_partial;
  logic [2*WIDTH-1:0] w_accSum;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_divRem;
  logic [WIDTH-1:0]   w_divQuot;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prodFixed;
  logic [WIDTH-1:0]   w_quotFixed;
  logic [WIDTH-1:0]   w_remFixed;

  // Request decode: magnitudes only matter for signed ops with a negative
  // operand. The most-negative value negates to itself, which read as
  // unsigned is exactly 2^(WIDTH-1), the magnitude we want.
  assign w_accept = bus.validIn && (r_state == IDLE);
  assign w_signA  = bus.op[0] & bus.SrcA[WIDTH-1];
  assign w_signB  = bus.op[0] & bus.SrcB[WIDTH-1];
  assign w_absA   = w_signA ? (-bus.SrcA) : bus.SrcA;
  assign w_absB   = w_signB ? (-bus.SrcB) : bus.SrcB;
  assign w_isDbz  = bus.op[1] && (bus.SrcB == '0);

  assign w_mulLast = (r_count == CW'(MUL_ITERS - 1));
  assign w_divLast = (r_count == CW'(DIV_ITERS - 1));

  assign w_mplierNext = r_mplier >> RADIX_BITS;

`ifdef MULT_EARLY_TERM_EN
  // Stop as soon as no set multiplier bits remain; a zero |SrcA| never
  // needs an iteration at all.
  assign w_mulDone = w_mulLast || (w_mplierNext == '0);
  assign w_mulSkip = (w_absA == '0);
`else
  assign w_mulDone = w_mulLast;
  assign w_mulSkip = 1'b0;
`endif

  // One radix digit times the shifted multiplicand. The multiplicand is
  // shifted at most WIDTH bits in total, so 2*WIDTH bits never overflow.
  assign w_partial = {{(2*WIDTH-RADIX_BITS){1'b0}}, r_mplier[RADIX_BITS-1:0]} * r_mcand;
  assign w_accSum  = {r_accHi, r_accLo} + w_partial;

  // Restoring divide step. The partial remainder is always below the
  // divisor, so the shifted value fits WIDTH+1 bits and the top bit of the
  // difference is a clean borrow flag.
  assign w_trial   = {r_accHi, r_accLo[WIDTH-1]};
  assign w_diff    = w_trial - {1'b0, r_mcand[WIDTH-1:0]};
  assign w_borrow  = w_diff[WIDTH];
  assign w_divRem  = w_borrow ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_divQuot = {r_accLo[WIDTH-2:0], ~w_borrow};

  // Sign correction applied in the FIX cycle. The remainder follows the
  // dividend's sign, the product and quotient follow signA^signB.
  assign w_prod      = {r_accHi, r_accLo};
  assign w_prodFixed = (r_signA ^ r_signB) ? (-w_prod) : w_prod;
  assign w_quotFixed = (r_signA ^ r_signB) ? (-r_accLo) : r_accLo;
  assign w_remFixed  = r_signA ? (-r_accHi) : r_accHi;

  // State register; reset drops any in-flight operation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A divide by zero has nothing to iterate, so it goes
  // straight to FIX where the fixed divide-by-zero result is published.
  always_comb begin
    w_nextState = r_state;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (w_accept) begin
          if (bus.op[1]) begin
            w_nextState = w_isDbz ? FIX : DIV;
          end else begin
            w_nextState = w_mulSkip ? FIX : MUL;
          end
        end
      end
      MUL: begin
        if (w_mulDone) begin
          w_nextState = FIX;
        end
      end
      DIV: begin
        if (w_divLast) begin
          w_nextState = FIX;
        end
      end
      FIX: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: operand capture on accept, one multiply or divide step per
  // cycle, and the result load in FIX. validOut is high only in the cycle
  // after FIX, which is already an IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_accHi      <= '0;
      r_accLo      <= '0;
      r_mplier     <= '0;
      r_mcand      <= '0;
      r_count      <= '0;
      r_signA      <= 1'b0;
      r_signB      <= 1'b0;
      r_isMul      <= 1'b0;
      r_dbzPending <= 1'b0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_dbz        <= 1'b0;
      r_validOut   <= 1'b0;
    end else begin
      r_validOut <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_isMul      <= ~bus.op[1];
            r_signA      <= w_signA;
            r_signB      <= w_signB;
            r_dbzPending <= w_isDbz;
            r_count      <= '0;
            r_mplier     <= w_absA;
            r_mcand      <= {{WIDTH{1'b0}}, w_absB};
            if (bus.op[1]) begin
              // Divide by zero preloads the final raw result here.
              r_accHi <= w_isDbz ? bus.SrcA : '0;
              r_accLo <= w_isDbz ? '1 : w_absA;
            end else begin
              r_accHi <= '0;
              r_accLo <= '0;
            end
          end
        end
        MUL: begin
          {r_accHi, r_accLo} <= w_accSum;
          r_mplier           <= w_mplierNext;
          r_mcand            <= r_mcand << RADIX_BITS;
          r_count            <= r_count + CW'(1);
        end
        DIV: begin
          r_accHi <= w_divRem;
          r_accLo <= w_divQuot;
          r_count <= r_count + CW'(1);
        end
        FIX: begin
          r_validOut <= 1'b1;
          r_dbz      <= r_dbzPending;
          if (r_isMul) begin
            r_hi <= w_prodFixed[2*WIDTH-1:WIDTH];
            r_lo <= w_prodFixed[WIDTH-1:0];
          end else if (r_dbzPending) begin
            r_hi <= r_accHi;
            r_lo <= r_accLo;
          end else begin
            r_hi <= w_remFixed;
            r_lo <= w_quotFixed;
          end
        end
        default: begin
          r_validOut <= 1'b0;
        end
      endcase
    end
  end

  assign bus.readyOut  = w_ready;
  assign bus.validOut  = r_validOut;
  assign bus.Hi        = r_hi;
  assign bus.Lo        = r_lo;
  assign bus.divByZero = r_dbz;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//
// Four engines (RADIX_BITS = 1, 2, 4, 8) share one stimulus stream; the
// RADIX_BITS=2 engine (index 1) carries most of the checks, all four are
// compared on the signed multiply case. Expected latencies follow the
// MULT_EARLY_TERM_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int MAIN = 1;

  logic        clk;
  logic        rst_n;
  logic        validIn;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;

  logic        vOut [4];
  logic        rdyW [4];
  logic [31:0] hiW  [4];
  logic [31:0] loW  [4];
  logic        dbzW [4];

  int checks   = 0;
  int passes   = 0;
  int failures = 0;

  int          lat    [4];
  int          pulses [4];
  logic [31:0] resHi  [4];
  logic [31:0] resLo  [4];
  logic        resDbz [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One engine per radix, all driven from the same request signals.
  for (genvar g = 0; g < 4; g++) begin : gEng
    mult_div_unit_if #(.WIDTH(32)) bus ();

    assign bus.validIn = validIn;
    assign bus.op      = op;
    assign bus.SrcA    = srcA;
    assign bus.SrcB    = srcB;

    assign vOut[g] = bus.validOut;
    assign rdyW[g] = bus.readyOut;
    assign hiW[g]  = bus.Hi;
    assign loW[g]  = bus.Lo;
    assign dbzW[g] = bus.divByZero;

    mult_div_unit #(.WIDTH(32), .RADIX_BITS(1 << g)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  // Expected edge (counted from the accepting edge) of the validOut pulse.
  function automatic int expLat(input int radix, input logic [1:0] o,
                                input logic [31:0] a, input logic [31:0] b);
    logic [31:0] absA;
    int          bl;
    if (o[1]) return (b == 32'd0) ? 1 : 33;
    absA = (o[0] && a[31]) ? (-a) : a;
    bl   = 0;
    for (int i = 0; i < 32; i++) if (absA[i]) bl = i + 1;
`ifdef MULT_EARLY_TERM_EN
    return (bl + radix - 1) / radix + 1;
`else
    if (bl < 0) return 0;
    return 32 / radix + 1;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; it is accepted on the following posedge.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    validIn = 1'b1;
    op      = o;
    srcA    = a;
    srcB    = b;
    @(posedge clk);
    #1;
    validIn = 1'b0;
  endtask

  // Count edges until every engine has pulsed validOut, capturing results
  // and pulse widths; bounded so a stuck engine still reaches the summary.
  task automatic waitAll();
    bit allSeen;
    bit anyValid;
    for (int i = 0; i < 4; i++) begin
      lat[i]    = 0;
      pulses[i] = 0;
    end
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      allSeen  = 1'b1;
      anyValid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (vOut[i]) begin
          pulses[i]++;
          anyValid = 1'b1;
          if (lat[i] == 0) begin
            lat[i]    = k;
            resHi[i]  = hiW[i];
            resLo[i]  = loW[i];
            resDbz[i] = dbzW[i];
          end
        end
        if (lat[i] == 0) allSeen = 1'b0;
      end
      if (allSeen && !anyValid) break;
    end
  endtask

  task automatic runCase(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eHi, input logic [31:0] eLo,
                         input logic eDbz, input bit allRadix);
    applyStimulus(o, a, b);
    waitAll();
    for (int i = 0; i < 4; i++) begin
      if (allRadix || i == MAIN) begin
        checkOutput($sformatf("%s r%0d latency", tag, 1 << i), 64'(lat[i]),
                    64'(expLat(1 << i, o, a, b)));
        checkOutput($sformatf("%s r%0d Hi", tag, 1 << i), 64'(resHi[i]), 64'(eHi));
        checkOutput($sformatf("%s r%0d Lo", tag, 1 << i), 64'(resLo[i]), 64'(eLo));
      end
    end
    checkOutput({tag, " divByZero"}, 64'(resDbz[MAIN]), 64'(eDbz));
    checkOutput({tag, " pulse width"}, 64'(pulses[MAIN]), 64'd1);
  endtask

  // Directed sequence: reset, multiplies, divides, corner cases, ignored
  // request while busy, and reset in the middle of a divide.
  initial begin
    int rdyHigh;
    int seenAt;
    int extra;
    logic [31:0] capHi;
    logic [31:0] capLo;

    rst_n   = 1'b0;
    validIn = 1'b0;
    op      = 2'b00;
    srcA    = 32'd0;
    srcB    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset readyOut",  64'(rdyW[MAIN]), 64'd1);
    checkOutput("reset validOut",  64'(vOut[MAIN]), 64'd0);
    checkOutput("reset Hi",        64'(hiW[MAIN]),  64'd0);
    checkOutput("reset Lo",        64'(loW[MAIN]),  64'd0);
    checkOutput("reset divByZero", 64'(dbzW[MAIN]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runCase("MULTU max*max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    runCase("MULT -3*5", 2'b01, 32'hFFFF_FFFD, 32'h0000_0005,
            32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold Hi", 64'(hiW[MAIN]), 64'hFFFF_FFFF);
    checkOutput("hold Lo", 64'(loW[MAIN]), 64'hFFFF_FFF1);

    runCase("MULT -4*-6", 2'b01, 32'hFFFF_FFFC, 32'hFFFF_FFFA,
            32'h0000_0000, 32'h0000_0018, 1'b0, 1'b0);
    runCase("DIV -7/2", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    runCase("DIV 7/-2", 2'b11, 32'h0000_0007, 32'hFFFF_FFFE,
            32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);
    runCase("DIV minneg/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
    runCase("DIVU 10/0", 2'b10, 32'h0000_000A, 32'h0000_0000,
            32'h0000_000A, 32'hFFFF_FFFF, 1'b1, 1'b0);
    runCase("DIV -5/0", 2'b11, 32'hFFFF_FFFB, 32'h0000_0000,
            32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);
    runCase("MULTU 2*3", 2'b00, 32'h0000_0002, 32'h0000_0003,
            32'h0000_0000, 32'h0000_0006, 1'b0, 1'b0);
    runCase("MULTU 3*7", 2'b00, 32'h0000_0003, 32'h0000_0007,
            32'h0000_0000, 32'h0000_0015, 1'b0, 1'b0);
    runCase("MULTU 0*X", 2'b00, 32'h0000_0000, 32'h0000_1234,
            32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);

    // A request pulsed while a divide is running must be dropped.
    applyStimulus(2'b10, 32'd100, 32'd7);
    rdyHigh = 0;
    seenAt  = 0;
    capHi   = '0;
    capLo   = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (k <= 32 && rdyW[MAIN]) rdyHigh++;
      if (vOut[MAIN] && seenAt == 0) begin
        seenAt = k;
        capHi  = hiW[MAIN];
        capLo  = loW[MAIN];
      end
      if (k == 5) begin
        validIn = 1'b1;
        op      = 2'b00;
        srcA    = 32'd5;
        srcB    = 32'd5;
      end
      if (k == 6) validIn = 1'b0;
      if (seenAt != 0 && k > seenAt) break;
    end
    checkOutput("busy DIVU latency", 64'(seenAt), 64'd33);
    checkOutput("busy DIVU Lo", 64'(capLo), 64'd14);
    checkOutput("busy DIVU Hi", 64'(capHi), 64'd2);
    checkOutput("busy readyOut high count", 64'(rdyHigh), 64'd0);
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (vOut[MAIN]) extra++;
    end
    checkOutput("busy no queued result", 64'(extra), 64'd0);

    // Reset at iteration 10 of a divide: immediate clear, no completion.
    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset Hi",       64'(hiW[MAIN]),  64'd0);
    checkOutput("midreset Lo",       64'(loW[MAIN]),  64'd0);
    checkOutput("midreset readyOut", 64'(rdyW[MAIN]), 64'd1);
    checkOutput("midreset validOut", 64'(vOut[MAIN]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (vOut[MAIN]) extra++;
    end
    checkOutput("midreset no validOut", 64'(extra), 64'd0);
    checkOutput("midreset idle readyOut", 64'(rdyW[MAIN]), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide engine for the ALU HI/LO path.
- Executes MULTU, MULT, DIVU and DIV on WIDTH-bit operands and delivers the results into held Hi/Lo registers.
- Multiply retires RADIX_BITS multiplier bits per cycle; divide is restoring, 1 quotient bit per cycle.
- Signed operations run on operand magnitudes, then a dedicated sign-fix cycle corrects the result; a ready/valid handshake lets the pipeline stall on HI/LO use.

Parameters:
- WIDTH, 32: operand width. Hi/Lo are WIDTH bits each.
- RADIX_BITS, 2: multiplier bits consumed per multiply iteration. Legal values: 1, 2, 4, 8. WIDTH % RADIX_BITS must be 0.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- validIn  in  1  request strobe; accepted only when readyOut=1
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- SrcA  in  WIDTH  multiplicand / dividend
- SrcB  in  WIDTH  multiplier / divisor
- readyOut  out  1  high in IDLE only
- validOut  out  1  one-cycle completion pulse
- Hi  out  WIDTH  product high half / remainder
- Lo  out  WIDTH  product low half / quotient
- divByZero  out  1  set on DIV/DIVU with SrcB=0; held with Hi/Lo

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - readyOut=1, validOut=0, Hi=0, Lo=0, divByZero=0.
  - Takes effect immediately, including mid-operation. The in-flight operation is discarded and no validOut is produced.
- States:
  - IDLE -> MUL on accept with op[1]=0.
  - IDLE -> DIV on accept with op[1]=1 and SrcB!=0.
  - IDLE -> FIX on accept of a divide with SrcB=0.
  - MUL -> FIX after WIDTH/RADIX_BITS iterations.
  - DIV -> FIX after WIDTH iterations.
  - FIX -> IDLE always.
- Accept: validIn=1 and state IDLE, sampled at a rising edge. The block latches op and the magnitudes of SrcA/SrcB. Magnitudes are taken only for op[0]=1 with a negative operand; they are WIDTH-bit unsigned, so the most-negative value maps to 2^(WIDTH-1).
- validIn outside IDLE: ignored, no queuing.
- MUL: each cycle adds (low RADIX_BITS of multiplier) * (shifted multiplicand) into a 2*WIDTH accumulator, then shifts the multiplier right and the multiplicand left by RADIX_BITS.
- DIV: restoring. Each cycle shifts the {rem,quot} pair left one bit, trial-subtracts the divisor, keeps the difference if non-negative and sets the quotient LSB.
- FIX:
  - Applies signs: product negated iff signA^signB; quotient negated iff signA^signB; remainder takes signA.
  - Registers Hi/Lo and divByZero, and drives validOut=1 for that one following cycle.
- Latency: validOut rises at rising edge N+1 after the accepting edge.
  - N = WIDTH/RADIX_BITS for multiply (17 at defaults).
  - N = WIDTH for divide (33 at defaults).
  - N = 0 for divide-by-zero.
- Back-to-back: readyOut=1 in the cycle validOut=1, so a new request may be accepted on the next edge. Hi/Lo hold their last result until the next FIX.
- Divide by zero: Hi=SrcA (raw, unsigned), Lo=all ones, divByZero=1, for both DIV and DIVU. divByZero clears at the next completion.
- DIV of the most-negative value by -1: Lo=most-negative (wrap), Hi=0, divByZero=0.
- Zero operands (no early termination): full N iterations still run; result 0.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined:
  - In MUL, if the remaining multiplier is 0 after an iteration, go to FIX next.
  - A multiply accepted with |SrcA|=0 goes straight to FIX (N=0).
  - N = ceil(bitlen(|SrcA|)/RADIX_BITS).
  - Results are identical to the fixed-latency build.
- Undefined: multiply latency is always the fixed N. Divide is unaffected either way.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF, defaults, macro off -> Hi=0xFFFFFFFE, Lo=0x00000001, validOut one cycle at edge 17 after accept.
- MULT 0xFFFFFFFD (-3) * 0x00000005 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Repeat with RADIX_BITS=1, 4, 8 -> same result, latency 33/9/5.
- DIV 0xFFFFFFF9 (-7) / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF at edge 33. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU 0x0000000A / 0 -> at edge 1: divByZero=1, Hi=0x0000000A, Lo=0xFFFFFFFF. A following MULTU 2*3 -> divByZero=0, Lo=6.
- validIn pulsed mid-DIV with other operands -> ignored; first result correct, readyOut=0 throughout. rst_n low at iteration 10 -> Hi=Lo=0, readyOut=1 immediately, no validOut.
- Macro on, RADIX_BITS=2: MULTU 3*7 -> Lo=21, Hi=0 at edge 2. MULTU 0*X -> result 0 at edge 1.
